// File: rtl/regfile_pkg.sv
// Shared constants and the write-resolution helper used by the register file and its scoreboard.
// Pure declarations: no state, no latency, no flow control.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int ZERO_REG     = 0;
    localparam int DEF_LINK_REG = DEF_NUM_REGS - 1;
    // Widest write-port count the resolver handles; NUM_WR must not exceed it.
    localparam int MAX_WR       = 16;

    // Highest-index set bit of a per-port match vector, or -1 when none matches.
    function automatic int highest_set(input logic [MAX_WR-1:0] v);
        int idx;
        idx = -1;
        for (int p = 0; p < MAX_WR; p++) begin
            if (v[p]) begin
                idx = p;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits (flush > issue > writeback clear) plus registered pending count.
// Updates at every rising edge; no backpressure, issue and writeback are always accepted.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                issue_en_i,
    input  logic [ADDR_W-1:0]   issue_addr_i,
    input  logic [NUM_REGS-1:0] written_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [ADDR_W:0]     pending_cnt_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     pending_q;
    logic [ADDR_W:0]     pending_d;

    always_comb begin
        busy_d    = busy_q;
        pending_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (issue_en_i && issue_addr_i == ADDR_W'(r) && r != ZERO_REG) begin
                // A new producer supersedes whichever write lands this edge.
                busy_d[r] = 1'b1;
            end else if (written_i[r]) begin
                busy_d[r] = 1'b0;
            end
            pending_d = pending_d + (ADDR_W+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign busy_o        = busy_q;
    assign pending_cnt_o = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass, link write and pending-write scoreboard.
// Reads are zero-latency, writes commit at the next edge; no backpressure on any port.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    parameter  int LINK_REG = NUM_REGS - 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     link_en,
    input  logic [DATA_W-1:0]        link_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_waw,
    input  logic                     flush,
    output logic [ADDR_W:0]          pending_cnt
);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   wr_win_dat [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [MAX_WR-1:0]   port_match;
    int                  win_port;
    logic [ADDR_W-1:0]   rd_a;

    // One resolution per target address feeds both the read bypass and the commit.
    always_comb begin
        port_match = '0;
        win_port   = -1;
        for (int r = 0; r < NUM_REGS; r++) begin
            port_match = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                port_match[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r));
            end
            win_port      = highest_set(port_match);
            wr_hit[r]     = 1'b0;
            wr_win_dat[r] = '0;
            if (win_port >= 0) begin
                wr_hit[r]     = 1'b1;
                wr_win_dat[r] = wr_data[win_port*DATA_W +: DATA_W];
            end
            if (link_en && r == LINK_REG) begin
                wr_hit[r]     = 1'b1;
                wr_win_dat[r] = link_data;
            end
            if (r == ZERO_REG) begin
                wr_hit[r]     = 1'b0;
                wr_win_dat[r] = '0;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            mem_d[r] = wr_hit[r] ? wr_win_dat[r] : mem_q[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_a    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_a = rd_addr[i*ADDR_W +: ADDR_W];
            if (rd_a == ADDR_W'(ZERO_REG)) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (wr_hit[rd_a]) begin
                rd_data[i*DATA_W +: DATA_W] = wr_win_dat[rd_a];
            end else begin
                rd_data[i*DATA_W +: DATA_W] = mem_q[rd_a];
            end
            // A write landing this cycle resolves the hazard; its data is already bypassed.
            rd_busy[i] = busy[rd_a] && !wr_hit[rd_a];
        end
    end

    assign issue_waw = busy[issue_addr];

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .issue_en_i    (issue_en),
        .issue_addr_i  (issue_addr),
        .written_i     (wr_hit),
        .busy_o        (busy),
        .pending_cnt_o (pending_cnt)
    );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file with an integrated per-register scoreboard, for the next-generation MIPS pipeline.
- Provides:
  - NUM_RD combinational read ports with same-cycle write-through bypass.
  - NUM_WR synchronous write ports plus a dedicated link-write port.
  - Pending-write tracking (busy bits, pending count) so issue logic can detect RAW/WAW hazards from multi-cycle units.
- Sits between decode/issue and writeback.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, register count (power of two, >= 2); ADDR_W = $clog2(NUM_REGS) is a derived localparam.
- NUM_RD, 2, number of read ports (>= 1).
- NUM_WR, 2, number of write ports (>= 1); a higher index has higher priority.
- LINK_REG, NUM_REGS-1, destination index of the link write.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies slice [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_busy  out  NUM_RD  addressed register pending, with no write resolving it this cycle.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- link_en  in  1  write link_data to LINK_REG; does not depend on wr_en.
- link_data  in  DATA_W  return address.
- issue_en  in  1  mark issue_addr pending.
- issue_addr  in  ADDR_W  destination of the issued instruction.
- issue_waw  out  1  busy[issue_addr], combinational.
- flush  in  1  synchronous clear of all busy bits.
- pending_cnt  out  ADDR_W+1  number of busy registers, registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Registers 1..NUM_REGS-1 := 0.
  - All busy bits := 0; pending_cnt := 0.
  - Reads therefore return 0 and rd_busy = 0.
- Register 0:
  - Reads return 0.
  - Writes and link writes targeting it are dropped.
  - Never busy; issue to it is ignored.
- Write resolution per target address, per cycle:
  - link_en has highest priority for LINK_REG.
  - Otherwise the highest-index enabled wr port whose address matches wins.
  - Non-conflicting ports all commit at the same edge.
- Read port i, combinational, in priority order:
  - addr 0 -> 0;
  - else same-cycle winning write to addr -> that data (bypass);
  - else the stored value.
- Read latency: zero cycles. Write commit: next rising edge.
- Scoreboard, next-state of busy[r] at each edge:
  - flush: all 0.
  - Otherwise set if issue_en && issue_addr==r && r!=0.
  - Otherwise clear if a winning write (wr or link) targets r.
  - Otherwise hold.
  - Same-edge issue and write to the same r: set wins (the new producer supersedes the old one).
- flush:
  - Discards any same-cycle issue.
  - Does not block same-cycle data writes.
- rd_busy[i] = busy[rd_addr_i] && !(same-cycle winning write to rd_addr_i); bypassed data is valid.
- pending_cnt:
  - Registered popcount of the next-state busy vector, updated every edge; max NUM_REGS-1.
  - Implemented as an incremental +1/-1/0 counter or a popcount; results must be identical.
  - Saturation is not needed: the count is bounded by construction.
- Write-address tracking:
  - A write to a non-busy register is legal and simply commits.
  - There is no error flag.
- Reset mid-operation: all state cleared immediately; in-flight writes are lost.

Decomposition:
- Package regfile_pkg:
  - DATA_W/NUM_REGS defaults.
  - ZERO_REG constant.
  - Default LINK_REG.
  - Function to compute the per-address winning-write one-hot/data (shared by bypass and commit).
- Sub-module regfile_scoreboard:
  - Owns the busy vector, flush/issue/clear priority and pending_cnt.
  - Consumes the per-address "written" vector produced by the main block.

Test Plan:
- Reset, then read all addresses -> rd_data=0, rd_busy=0, pending_cnt=0; write r5=0xDEADBEEF on wr0, read r5 same cycle -> 0xDEADBEEF (bypass); next cycle -> 0xDEADBEEF from storage.
- wr0 and wr1 both to r7 (0x11, 0x22) with link_en=1 link_data=0x400 -> r7=0x22, r31=0x400; wr1 to r31=0x55 with link_en -> r31=0x400.
- Write r0=0xFFFF_FFFF and issue r0 -> r0 reads 0, pending_cnt unchanged.
- Issue r3 and r9 -> pending_cnt=2, rd_busy for r3=1; writeback r3 -> rd_busy=0 in the writeback cycle (bypass), pending_cnt=1 after the edge; issue_addr=r9 -> issue_waw=1.
- Same edge: issue r4 and write r4 (r4 busy beforehand) -> r4 stays busy, data updated; flush with issue r6 -> all busy=0, pending_cnt=0, r6 not busy.
- Assert rst_n low asynchronously mid-cycle with busy=3 regs and data stored -> outputs 0 immediately, no clk edge required.
